snitch_regfile_wb_ctrl: RTL and testbench

Write-back controller and scoreboard for the integer register file `snitch_regfile`. It shares the file's single write port between `NrReq` write-back requesters, for example ALU, LSU response and accelerator response, using round-robin arbitration. It also keeps a per-register busy scoreboard for long-latency destinations and reports read hazards to the issue stage. It sits between the core's execution units and the register file's `we`/`waddr`/`wdata` port.

---
 rtl/snitch_regfile_wb_ctrl_if.sv | 36 +++
 rtl/snitch_regfile_wb_ctrl.sv | 139 +++++++++++++
 tb/tb_snitch_regfile_wb_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/snitch_regfile_wb_ctrl_if.sv
// Bundle of write-back, issue-marking, register-file and hazard signals
// exchanged between the core side and the write-back controller.
interface snitch_regfile_wb_ctrl_if #(
    parameter int unsigned NrReq       = 3,
    parameter int unsigned AddrWidth   = 5,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned NrReadPorts = 2
);
    // Issue stage marking a long-latency destination
    logic                                   issue_valid;
    logic [AddrWidth-1:0]                   issue_rd;
    logic                                   issue_ready;
    // Write-back requesters
    logic [NrReq-1:0]                       wb_valid;
    logic [NrReq-1:0][AddrWidth-1:0]        wb_addr;
    logic [NrReq-1:0][DataWidth-1:0]        wb_data;
    logic [NrReq-1:0]                       wb_ready;
    // Register file write port
    logic                                   rf_we;
    logic [AddrWidth-1:0]                   rf_waddr;
    logic [DataWidth-1:0]                   rf_wdata;
    // Operand hazard checks and scoreboard view
    logic [NrReadPorts-1:0][AddrWidth-1:0]  hazard_raddr;
    logic [NrReadPorts-1:0]                 hazard;
    logic [2**AddrWidth-1:0]                busy;

    modport master (
        output issue_valid, issue_rd, wb_valid, wb_addr, wb_data, hazard_raddr,
        input  issue_ready, wb_ready, rf_we, rf_waddr, rf_wdata, hazard, busy
    );

    modport slave (
        input  issue_valid, issue_rd, wb_valid, wb_addr, wb_data, hazard_raddr,
        output issue_ready, wb_ready, rf_we, rf_waddr, rf_wdata, hazard, busy
    );
endinterface

// File: rtl/snitch_regfile_wb_ctrl.sv
// Write-back controller for snitch_regfile: round-robin sharing of the single
// write port among NrReq requesters, plus a per-register busy scoreboard for
// long-latency destinations that drives operand hazard flags.
module snitch_regfile_wb_ctrl #(
    parameter int unsigned NrReq       = 3,
    parameter int unsigned AddrWidth   = 5,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned NrReadPorts = 2,
    parameter bit          ZeroRegZero = 1'b1
) (
    input logic                   clk_i,
    input logic                   rst_i,
    snitch_regfile_wb_ctrl_if.slave bus
);
    localparam int unsigned NrRegs  = 2**AddrWidth;
    localparam int unsigned RrWidth = (NrReq > 1) ? $clog2(NrReq) : 1;

    // True when addr names the hardwired-zero register
    function automatic logic is_zero_reg(input logic [AddrWidth-1:0] addr);
        return ZeroRegZero && (addr == {AddrWidth{1'b0}});
    endfunction

    logic [NrRegs-1:0]    busy_r;
    logic [NrRegs-1:0]    busy_next_s;
    logic [RrWidth-1:0]   rr_r;
    logic [RrWidth-1:0]   rr_next_s;

    logic [2*NrReq-1:0]   rotated_s;
    logic                 grant_s;
    logic [RrWidth-1:0]   grant_idx_s;
    logic [NrReq-1:0]     wb_ready_s;
    logic                 rf_we_s;
    logic [AddrWidth-1:0] rf_waddr_s;
    logic [DataWidth-1:0] rf_wdata_s;
    logic                 issue_ready_s;
    logic                 issue_fire_s;
    logic [NrReadPorts-1:0] hazard_s;

    // Round-robin search: rotate requests so rr_r lands at bit 0, take first set
    always_comb begin
        rotated_s   = {bus.wb_valid, bus.wb_valid} >> rr_r;
        grant_s     = 1'b0;
        grant_idx_s = {RrWidth{1'b0}};
        for (int unsigned k = 0; k < NrReq; k++) begin
            if (!rst_i && !grant_s && rotated_s[k]) begin
                grant_s     = 1'b1;
                grant_idx_s = RrWidth'((32'(rr_r) + k) % NrReq);
            end else begin
                grant_s     = grant_s;
            end
        end
    end

    // Grant vector and register-file write port mux; x0 writes are swallowed
    always_comb begin
        wb_ready_s = {NrReq{1'b0}};
        rf_we_s    = 1'b0;
        rf_waddr_s = {AddrWidth{1'b0}};
        rf_wdata_s = {DataWidth{1'b0}};
        if (grant_s) begin
            wb_ready_s[grant_idx_s] = 1'b1;
            rf_waddr_s              = bus.wb_addr[grant_idx_s];
            rf_wdata_s              = bus.wb_data[grant_idx_s];
            rf_we_s                 = !is_zero_reg(bus.wb_addr[grant_idx_s]);
        end else begin
            rf_we_s = 1'b0;
        end
    end

    // Issue acceptance looks only at registered busy state (no wb_valid path)
    always_comb begin
        if (rst_i) begin
            issue_ready_s = 1'b0;
        end else if (is_zero_reg(bus.issue_rd)) begin
            issue_ready_s = 1'b1;
        end else begin
            issue_ready_s = !busy_r[bus.issue_rd];
        end
        issue_fire_s = bus.issue_valid && issue_ready_s && !is_zero_reg(bus.issue_rd);
    end

    // Operand hazard: still busy, or being written this cycle
    always_comb begin
        hazard_s = {NrReadPorts{1'b0}};
        for (int unsigned p = 0; p < NrReadPorts; p++) begin
            if (is_zero_reg(bus.hazard_raddr[p])) begin
                hazard_s[p] = 1'b0;
            end else begin
                hazard_s[p] = busy_r[bus.hazard_raddr[p]] ||
                              (rf_we_s && (rf_waddr_s == bus.hazard_raddr[p]));
            end
        end
    end

    // Next scoreboard and pointer: clear on write, then set on accepted mark
    always_comb begin
        busy_next_s = busy_r;
        if (rf_we_s) begin
            busy_next_s[rf_waddr_s] = 1'b0;
        end else begin
            busy_next_s = busy_next_s;
        end
        if (issue_fire_s) begin
            busy_next_s[bus.issue_rd] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
        rr_next_s = rr_r;
        if (grant_s) begin
            if (grant_idx_s == RrWidth'(NrReq - 1)) begin
                rr_next_s = {RrWidth{1'b0}};
            end else begin
                rr_next_s = grant_idx_s + {{(RrWidth-1){1'b0}}, 1'b1};
            end
        end else begin
            rr_next_s = rr_r;
        end
    end

    // Scoreboard and round-robin pointer registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_r <= {NrRegs{1'b0}};
            rr_r   <= {RrWidth{1'b0}};
        end else begin
            busy_r <= busy_next_s;
            rr_r   <= rr_next_s;
        end
    end

    assign bus.wb_ready    = wb_ready_s;
    assign bus.rf_we       = rf_we_s;
    assign bus.rf_waddr    = rf_waddr_s;
    assign bus.rf_wdata    = rf_wdata_s;
    assign bus.issue_ready = issue_ready_s;
    assign bus.hazard      = hazard_s;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_snitch_regfile_wb_ctrl.sv
// Self-checking bench for snitch_regfile_wb_ctrl: directed vector table,
// hand-written multi-cycle sequences and constrained-random traffic, all
// cross-checked every cycle against a cycle-level reference model.
module tb_snitch_regfile_wb_ctrl;
    logic clk;
    logic rst;
    logic [2:0]  valid;
    logic [4:0]  addr  [3];
    logic [31:0] data  [3];
    logic        iv;
    logic [4:0]  rd;
    logic [4:0]  raddr [2];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mbusy;
    int          mrr;
    // Expectations of the current cycle, used when the model advances
    int          e_g;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic        e_ir;

    snitch_regfile_wb_ctrl_if bus ();

    assign bus.wb_valid     = valid;
    assign bus.wb_addr      = {addr[2], addr[1], addr[0]};
    assign bus.wb_data      = {data[2], data[1], data[0]};
    assign bus.issue_valid  = iv;
    assign bus.issue_rd     = rd;
    assign bus.hazard_raddr = {raddr[1], raddr[0]};

    snitch_regfile_wb_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit r, input bit [2:0] v, input bit [4:0] a0, input bit [4:0] a1,
                          input bit [4:0] a2, input bit i_v, input bit [4:0] i_rd, input bit [4:0] ra);
        rst = r; valid = v;
        addr[0] = a0; addr[1] = a1; addr[2] = a2;
        iv = i_v; rd = i_rd;
        raddr[0] = ra; raddr[1] = ra;
    endtask

    // Compute expectations from the model at mid-cycle and compare all outputs
    task automatic settle();
        logic [2:0]  e_ready;
        logic [31:0] e_wdata;
        logic [1:0]  e_haz;
        @(negedge clk);
        e_g = -1;
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (e_g < 0 && valid[(mrr + k) % 3]) e_g = (mrr + k) % 3;
            end
        end
        e_ready = (e_g >= 0) ? (3'b001 << e_g) : 3'b000;
        e_waddr = (e_g >= 0) ? addr[e_g] : 5'd0;
        e_wdata = (e_g >= 0) ? data[e_g] : 32'd0;
        e_we    = (e_g >= 0) && (addr[e_g] != 5'd0);
        e_ir    = rst ? 1'b0 : ((rd == 5'd0) ? 1'b1 : !mbusy[rd]);
        for (int p = 0; p < 2; p++) begin
            e_haz[p] = (raddr[p] != 5'd0) && (mbusy[raddr[p]] || (e_we && e_waddr == raddr[p]));
        end
        chk("wb_ready", bus.wb_ready, e_ready);
        chk("rf_we", bus.rf_we, e_we);
        chk("rf_waddr", bus.rf_waddr, e_waddr);
        chk("rf_wdata", bus.rf_wdata, e_wdata);
        chk("issue_ready", bus.issue_ready, e_ir);
        chk("hazard", bus.hazard, e_haz);
        chk("busy", bus.busy, mbusy);
    endtask

    // Step the model across the clock edge
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            mbusy = 32'd0;
            mrr   = 0;
        end else begin
            if (e_g >= 0) mrr = (e_g + 1) % 3;
            if (e_we) mbusy[e_waddr] = 1'b0;
            if (iv && e_ir && rd != 5'd0) mbusy[rd] = 1'b1;
        end
        #1;
    endtask

    typedef struct {
        bit       r;
        bit [2:0] v;
        bit       i_v;
        bit [4:0] i_rd;
        bit [4:0] ra;
        bit [4:0] a0;
        bit [2:0] x_ready;
        bit       x_we;
        bit [4:0] x_waddr;
        bit       x_ir;
        bit [1:0] x_haz;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // Reset with all requesters pending, then round-robin over addresses 1,2,3
        tbl[0] = '{1'b1, 3'b111, 1'b0, 5'd0, 5'd0, 5'd1, 3'b000, 1'b0, 5'd0, 1'b0, 2'b00};
        tbl[1] = '{1'b1, 3'b111, 1'b0, 5'd0, 5'd0, 5'd1, 3'b000, 1'b0, 5'd0, 1'b0, 2'b00};
        tbl[2] = '{1'b0, 3'b111, 1'b0, 5'd0, 5'd0, 5'd1, 3'b001, 1'b1, 5'd1, 1'b1, 2'b00};
        tbl[3] = '{1'b0, 3'b111, 1'b0, 5'd0, 5'd0, 5'd1, 3'b010, 1'b1, 5'd2, 1'b1, 2'b00};
        tbl[4] = '{1'b0, 3'b111, 1'b0, 5'd0, 5'd0, 5'd1, 3'b100, 1'b1, 5'd3, 1'b1, 2'b00};
        tbl[5] = '{1'b0, 3'b111, 1'b0, 5'd0, 5'd0, 5'd1, 3'b001, 1'b1, 5'd1, 1'b1, 2'b00};
        tbl[6] = '{1'b0, 3'b111, 1'b0, 5'd0, 5'd0, 5'd1, 3'b010, 1'b1, 5'd2, 1'b1, 2'b00};
        tbl[7] = '{1'b0, 3'b111, 1'b0, 5'd0, 5'd0, 5'd1, 3'b100, 1'b1, 5'd3, 1'b1, 2'b00};
        // x0 write-back is granted but not written; x0 issue is always ready
        tbl[8] = '{1'b0, 3'b001, 1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b0, 5'd0, 1'b1, 2'b00};
        tbl[9] = '{1'b0, 3'b000, 1'b1, 5'd0, 5'd0, 5'd1, 3'b000, 1'b0, 5'd0, 1'b1, 2'b00};

        data[0] = 32'h0000_00A0; data[1] = 32'h0000_00B1; data[2] = 32'h0000_00C2;
        mbusy = 32'd0; mrr = 0;
        set_in(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].r, tbl[i].v, tbl[i].a0, 5'd2, 5'd3, tbl[i].i_v, tbl[i].i_rd, tbl[i].ra);
            settle();
            chk($sformatf("vec%0d_ready", i), bus.wb_ready, tbl[i].x_ready);
            chk($sformatf("vec%0d_we", i), bus.rf_we, tbl[i].x_we);
            chk($sformatf("vec%0d_waddr", i), bus.rf_waddr, tbl[i].x_waddr);
            chk($sformatf("vec%0d_ir", i), bus.issue_ready, tbl[i].x_ir);
            chk($sformatf("vec%0d_haz", i), bus.hazard, tbl[i].x_haz);
            advance();
        end
        set_in(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
        settle();
        chk("x0_busy", bus.busy[0], 1'b0);
        advance();

        // Scoreboard: mark x5, later written back by requester 1
        set_in(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd5);
        settle(); chk("sb_c0_haz", bus.hazard, 2'b00); advance();
        set_in(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd5);
        settle(); chk("sb_c1_busy5", bus.busy[5], 1'b1); chk("sb_c1_haz", bus.hazard, 2'b11); advance();
        settle(); advance();
        settle(); advance();
        set_in(1'b0, 3'b010, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 5'd5);
        data[1] = 32'hDEAD_BEEF;
        settle();
        chk("sb_c4_we", bus.rf_we, 1'b1);
        chk("sb_c4_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
        chk("sb_c4_haz", bus.hazard, 2'b11);
        advance();
        set_in(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd5);
        settle(); chk("sb_c5_haz", bus.hazard, 2'b00); chk("sb_c5_busy5", bus.busy[5], 1'b0); advance();

        // WAW: issue x7 while busy x7 is being written back
        set_in(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd7);
        settle(); advance();
        set_in(1'b0, 3'b001, 5'd7, 5'd0, 5'd0, 1'b1, 5'd7, 5'd7);
        settle(); chk("waw_ir0", bus.issue_ready, 1'b0); chk("waw_we", bus.rf_we, 1'b1); advance();
        set_in(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd7);
        settle(); chk("waw_ir1", bus.issue_ready, 1'b1); advance();
        set_in(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd7);
        settle(); chk("waw_busy7", bus.busy[7], 1'b1); advance();

        // Issue x9 while non-busy x9 is written: set wins
        set_in(1'b0, 3'b001, 5'd9, 5'd0, 5'd0, 1'b1, 5'd9, 5'd0);
        settle(); chk("sim9_ir", bus.issue_ready, 1'b1); advance();
        set_in(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
        settle(); chk("sim9_busy9", bus.busy[9], 1'b1); advance();

        // Reset mid-operation after marking 3, 4, 6 and moving the pointer
        set_in(1'b0, 3'b001, 5'd10, 5'd0, 5'd0, 1'b1, 5'd3, 5'd0);
        settle(); advance();
        set_in(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd4, 5'd0);
        settle(); advance();
        set_in(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd6, 5'd0);
        settle(); advance();
        set_in(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
        settle(); chk("mid_marks", bus.busy & 32'h0000_0058, 32'h0000_0058); advance();
        set_in(1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 5'd0);
        settle(); chk("mid_busy0", bus.busy, 32'd0); chk("mid_grant0", bus.wb_ready, 3'b001); advance();

        // Constrained random traffic; ungranted requesters hold their request
        for (int n = 0; n < 3000; n++) begin
            bit was_rst;
            was_rst = rst;
            for (int i = 0; i < 3; i++) begin
                if (!valid[i] || e_g == i || was_rst) begin
                    valid[i] = $urandom_range(0, 1);
                    addr[i]  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                    data[i]  = $urandom;
                end
            end
            rst      = ($urandom_range(0, 199) == 0);
            iv       = $urandom_range(0, 1);
            rd       = 5'($urandom_range(0, 7));
            raddr[0] = 5'($urandom_range(0, 7));
            raddr[1] = 5'($urandom_range(0, 7));
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
